dmem_latency_responder: RTL

//  Multi-cycle data-memory responder for the pipelined CPU's MEM stage. Accepts one

---
 rtl/dmem_resp_pkg.sv | 11 +
 rtl/dmem_latency_responder_if.sv | 25 ++
 rtl/dmem_word_array.sv | 51 +++++
 rtl/dmem_latency_responder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared types and widths for the multi-cycle data-memory responder.
package dmem_resp_pkg;
   localparam int DATA_W = 32;
   localparam int LAT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;
endpackage

// File: rtl/dmem_latency_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
interface dmem_latency_responder_if #(
   parameter int AW = 32
);
   import dmem_resp_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [AW-1:0]     req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_word_array.sv
// Word-addressed storage with synchronous write, registered read and a synchronous full clear.
module dmem_word_array
   import dmem_resp_pkg::*;
#(
   parameter int DEPTH = 16384,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              we,
   input  logic              re,
   input  logic              rd_zero,
   input  logic [IW-1:0]     idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   // Stores and rejected accesses return zero instead of the addressed word.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         if (rd_zero) begin
            rdata_d = '0;
         end else begin
            rdata_d = mem_q[idx];
         end
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Clear wins over a same-cycle write so an aborted store never lands.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rdata_q <= '0;
      end else begin
         if (we) begin
            mem_q[idx] <= wdata;
         end
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/dmem_latency_responder.sv
// Fixed-latency data-memory responder: one load/store per handshake, one response pulse
// LATENCY cycles after the accept edge.
module dmem_latency_responder
   import dmem_resp_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int DEPTH   = 16384,
   parameter int AW      = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   dmem_latency_responder_if.slave bus
);
   localparam int               IW       = $clog2(DEPTH);
   localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY - 1);

   state_e            state_q,      state_d;
   logic [LAT_W-1:0]  cnt_q,        cnt_d;
   logic              wr_q,         wr_d;
   logic [AW-1:0]     addr_q,       addr_d;
   logic [DATA_W-1:0] wdata_q,      wdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q,   resp_err_d;

   logic [AW-1:0]     widx_s;
   logic              err_s;
   logic              arr_we_s;
   logic              arr_re_s;
   logic              arr_zero_s;
   logic [DATA_W-1:0] arr_rdata_s;

   assign widx_s = {2'b00, addr_q[AW-1:2]};
   assign err_s  = (addr_q[1:0] != 2'b00) || (widx_s >= AW'(DEPTH));

   // Next-state, counter and array-strobe decode.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      arr_we_s     = 1'b0;
      arr_re_s     = 1'b0;
      arr_zero_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               wr_d    = bus.req_write;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               cnt_d   = CNT_INIT;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (cnt_q != {LAT_W{1'b0}}) begin
               cnt_d = cnt_q - LAT_W'(1);
            end else begin
               // Access edge: commit the store or capture the load word.
               arr_we_s     = wr_q & ~err_s;
               arr_re_s     = 1'b1;
               arr_zero_s   = wr_q | err_s;
               resp_valid_d = 1'b1;
               resp_err_d   = err_s;
               state_d      = RESP;
            end
         end
         RESP: begin
            resp_valid_d = 1'b0;
            state_d      = IDLE;
         end
         default: begin
            resp_valid_d = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   // State and request latches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
      end
   end

   dmem_word_array #(
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_array (
      .clk     (clk),
      .clear   (reset),
      .we      (arr_we_s),
      .re      (arr_re_s),
      .rd_zero (arr_zero_s),
      .idx     (widx_s[IW-1:0]),
      .wdata   (wdata_q),
      .rdata   (arr_rdata_s)
   );

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = arr_rdata_s;
endmodule
